// File: rtl/kb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kb_pkg
//  Brief    : Shared constants and types for the keypad numeric-entry path.
//  Revision : 1.0 - initial release
// ============================================================================
package kb_pkg;

    localparam logic [7:0]  KB_ASCII_ZERO  = 8'h30;
    localparam logic [7:0]  KB_ASCII_NINE  = 8'h39;
    localparam logic [7:0]  KB_ASCII_BKSP  = 8'h08;
    localparam logic [7:0]  KB_ASCII_ENTER = 8'h0D;
    localparam logic [7:0]  KB_ASCII_ESC   = 8'h1B;

    localparam logic [31:0] KB_BUF_BLANK   = 32'h3030_3030;
    localparam logic [2:0]  KB_MAX_DIGITS  = 3'd4;

    typedef enum logic [2:0] {
        KEY_DIGIT = 3'd0,
        KEY_BKSP  = 3'd1,
        KEY_ENTER = 3'd2,
        KEY_ESC   = 3'd3,
        KEY_OTHER = 3'd4
    } kb_key_class_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_COMMIT = 2'd2
    } kb_entry_state_t;

endpackage
`default_nettype wire

// File: rtl/kb_entry_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : kb_entry_ctrl_if
//  Brief    : Keystroke input and committed-buffer handshake bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface kb_entry_ctrl_if;

    logic [7:0]  key_data;
    logic        key_valid;
    logic        buffer_ready;
    logic [31:0] buffer;
    logic        buffer_valid;
    logic [2:0]  digit_count;
    logic        entry_active;
    logic        err_pulse;

    // master: keystroke source / buffer consumer side
    modport master (
        output key_data, key_valid, buffer_ready,
        input  buffer, buffer_valid, digit_count, entry_active, err_pulse
    );

    // slave: the entry controller
    modport slave (
        input  key_data, key_valid, buffer_ready,
        output buffer, buffer_valid, digit_count, entry_active, err_pulse
    );

endinterface
`default_nettype wire

// File: rtl/kb_key_classify.sv
`default_nettype none
// ============================================================================
//  Module   : kb_key_classify
//  Brief    : Combinational ASCII keystroke classifier.
//  Revision : 1.0 - initial release
// ============================================================================
module kb_key_classify
    import kb_pkg::*;
(
    input  wire logic [7:0] key_data,
    output kb_key_class_t   key_class
);

    always_comb begin
        key_class = KEY_OTHER;
        if ((key_data >= KB_ASCII_ZERO) && (key_data <= KB_ASCII_NINE)) begin
            key_class = KEY_DIGIT;
        end else if (key_data == KB_ASCII_BKSP) begin
            key_class = KEY_BKSP;
        end else if (key_data == KB_ASCII_ENTER) begin
            key_class = KEY_ENTER;
        end else if (key_data == KB_ASCII_ESC) begin
            key_class = KEY_ESC;
        end
    end

endmodule
`default_nettype wire

// File: rtl/kb_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : kb_entry_ctrl
//  Brief    : Keypad entry sequencer: 4-digit ASCII shift buffer, commit
//             handshake and idle auto-clear.
//  Revision : 1.0 - initial release
// ============================================================================
module kb_entry_ctrl
    import kb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
)(
    input  wire logic     clk,
    input  wire logic     rst,
    kb_entry_ctrl_if.slave bus
);

    localparam logic        c_timeout_en   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] c_timeout_last = 32'(TIMEOUT_CYCLES - 1);

    kb_entry_state_t r_state;
    logic [31:0]     r_buffer;
    logic            r_buffer_valid;
    logic [2:0]      r_count;
    logic            r_entry_active;
    logic            r_err_pulse;
    logic [31:0]     r_timer;

    kb_key_class_t   w_key_class;
    logic            w_timeout_hit;

    kb_key_classify u_classify (
        .key_data  (bus.key_data),
        .key_class (w_key_class)
    );

    assign w_timeout_hit = c_timeout_en && (r_timer == c_timeout_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_EMPTY;
            r_buffer       <= KB_BUF_BLANK;
            r_buffer_valid <= 1'b0;
            r_count        <= 3'd0;
            r_entry_active <= 1'b0;
            r_err_pulse    <= 1'b0;
            r_timer        <= 32'd0;
        end else begin
            r_err_pulse <= 1'b0;
            case (r_state)
                ST_EMPTY, ST_ENTRY: begin
                    if (bus.key_valid) begin
                        r_timer <= 32'd0;
                        case (w_key_class)
                            KEY_DIGIT: begin
                                if (r_count < KB_MAX_DIGITS) begin
                                    r_buffer       <= {r_buffer[23:0], bus.key_data};
                                    r_count        <= r_count + 3'd1;
                                    r_state        <= ST_ENTRY;
                                    r_entry_active <= 1'b1;
                                end else begin
                                    r_err_pulse <= 1'b1;
                                end
                            end
                            KEY_BKSP: begin
                                if (r_count != 3'd0) begin
                                    r_buffer <= {KB_ASCII_ZERO, r_buffer[31:8]};
                                    r_count  <= r_count - 3'd1;
                                    if (r_count == 3'd1) begin
                                        r_state        <= ST_EMPTY;
                                        r_entry_active <= 1'b0;
                                    end
                                end else begin
                                    r_err_pulse <= 1'b1;
                                end
                            end
                            KEY_ENTER: begin
                                if (r_state == ST_ENTRY) begin
                                    r_state        <= ST_COMMIT;
                                    r_buffer_valid <= 1'b1;
                                    r_entry_active <= 1'b0;
                                end else begin
                                    r_err_pulse <= 1'b1;
                                end
                            end
                            KEY_ESC: begin
                                r_state        <= ST_EMPTY;
                                r_buffer       <= KB_BUF_BLANK;
                                r_count        <= 3'd0;
                                r_entry_active <= 1'b0;
                            end
                            default: ;
                        endcase
                    end else if (r_state == ST_ENTRY) begin
                        // Idle expiry behaves like ESC, silently
                        if (w_timeout_hit) begin
                            r_state        <= ST_EMPTY;
                            r_buffer       <= KB_BUF_BLANK;
                            r_count        <= 3'd0;
                            r_entry_active <= 1'b0;
                            r_timer        <= 32'd0;
                        end else begin
                            r_timer <= r_timer + 32'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (bus.key_valid) begin
                        r_err_pulse <= 1'b1;
                    end
                    if (bus.buffer_ready) begin
                        r_state        <= ST_EMPTY;
                        r_buffer       <= KB_BUF_BLANK;
                        r_count        <= 3'd0;
                        r_buffer_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= ST_EMPTY;
                    r_buffer       <= KB_BUF_BLANK;
                    r_buffer_valid <= 1'b0;
                    r_count        <= 3'd0;
                    r_entry_active <= 1'b0;
                    r_timer        <= 32'd0;
                end
            endcase
        end
    end

    assign bus.buffer       = r_buffer;
    assign bus.buffer_valid = r_buffer_valid;
    assign bus.digit_count  = r_count;
    assign bus.entry_active = r_entry_active;
    assign bus.err_pulse    = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_kb_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kb_entry_ctrl
//  Brief    : Self-checking bench for kb_entry_ctrl (vector table + scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_kb_entry_ctrl;

    localparam logic [31:0] B0 = 32'h3030_3030;

    typedef struct {
        int          id;
        logic        rst;
        logic        kv;
        logic [7:0]  kd;
        logic        rdy;
        logic [31:0] e_buf;
        logic        e_val;
        logic [2:0]  e_cnt;
        logic        e_act;
        logic        e_err;
    } vec_t;

    vec_t vec_q[$];
    vec_t exp_q[$];
    int   next_id = 0;
    int   checks  = 0;
    int   errors  = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    kb_entry_ctrl_if bus();

    kb_entry_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic kv, logic [7:0] kd, logic rdy,
                                logic [31:0] eb, logic ev, logic [2:0] ec,
                                logic ea, logic ee);
        vec_t v;
        v.id = next_id; next_id++;
        v.rst = r; v.kv = kv; v.kd = kd; v.rdy = rdy;
        v.e_buf = eb; v.e_val = ev; v.e_cnt = ec; v.e_act = ea; v.e_err = ee;
        return v;
    endfunction

    function automatic void add(logic r, logic kv, logic [7:0] kd, logic rdy,
                                logic [31:0] eb, logic ev, logic [2:0] ec,
                                logic ea, logic ee);
        vec_q.push_back(mk(r, kv, kd, rdy, eb, ev, ec, ea, ee));
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst              = v.rst;
        bus.key_valid    = v.kv;
        bus.key_data     = v.kd;
        bus.buffer_ready = v.rdy;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard vec %0d: got empty queue expected entry", v.id);
        end else begin
            e = exp_q.pop_front();
            chk("buffer",       e.id, bus.buffer,                e.e_buf);
            chk("buffer_valid", e.id, {31'd0, bus.buffer_valid}, {31'd0, e.e_val});
            chk("digit_count",  e.id, {29'd0, bus.digit_count},  {29'd0, e.e_cnt});
            chk("entry_active", e.id, {31'd0, bus.entry_active}, {31'd0, e.e_act});
            chk("err_pulse",    e.id, {31'd0, bus.err_pulse},    {31'd0, e.e_err});
        end
    endtask

    initial begin
        bus.key_valid    = 1'b0;
        bus.key_data     = 8'h00;
        bus.buffer_ready = 1'b0;

        //  rst kv  key    rdy  buffer         val cnt act err
        // reset, with a key in the same cycle that must be ignored
        add(1, 1, 8'h35, 0, B0,            0, 0, 0, 0);
        add(0, 0, 8'h00, 0, B0,            0, 0, 0, 0);
        // '4','2',ENTER with ready high: one valid cycle then blank
        add(0, 1, 8'h34, 1, 32'h30303034,  0, 1, 1, 0);
        add(0, 1, 8'h32, 1, 32'h30303432,  0, 2, 1, 0);
        add(0, 1, 8'h0D, 1, 32'h30303432,  1, 2, 0, 0);
        add(0, 0, 8'h00, 1, B0,            0, 0, 0, 0);
        // '1'..'5': fifth digit rejected
        add(0, 1, 8'h31, 0, 32'h30303031,  0, 1, 1, 0);
        add(0, 1, 8'h32, 0, 32'h30303132,  0, 2, 1, 0);
        add(0, 1, 8'h33, 0, 32'h30313233,  0, 3, 1, 0);
        add(0, 1, 8'h34, 0, 32'h31323334,  0, 4, 1, 0);
        add(0, 1, 8'h35, 0, 32'h31323334,  0, 4, 1, 1);
        add(0, 0, 8'h00, 0, 32'h31323334,  0, 4, 1, 0);
        add(0, 1, 8'h1B, 0, B0,            0, 0, 0, 0);
        add(0, 1, 8'h1B, 0, B0,            0, 0, 0, 0);
        // '9','8',BKSP x3, then ENTER and OTHER in EMPTY
        add(0, 1, 8'h39, 0, 32'h30303039,  0, 1, 1, 0);
        add(0, 1, 8'h38, 0, 32'h30303938,  0, 2, 1, 0);
        add(0, 1, 8'h08, 0, 32'h30303039,  0, 1, 1, 0);
        add(0, 1, 8'h08, 0, B0,            0, 0, 0, 0);
        add(0, 1, 8'h08, 0, B0,            0, 0, 0, 1);
        add(0, 1, 8'h0D, 0, B0,            0, 0, 0, 1);
        add(0, 1, 8'h41, 0, B0,            0, 0, 0, 0);
        // digit-range edges: 0x2F and 0x3A are OTHER, 0x30/0x39 are digits
        add(0, 1, 8'h2F, 0, B0,            0, 0, 0, 0);
        add(0, 1, 8'h3A, 0, B0,            0, 0, 0, 0);
        add(0, 1, 8'h30, 0, B0,            0, 1, 1, 0);
        add(0, 1, 8'h39, 0, 32'h30303039,  0, 2, 1, 0);
        add(0, 1, 8'h78, 0, 32'h30303039,  0, 2, 1, 0);
        add(0, 1, 8'h1B, 0, B0,            0, 0, 0, 0);
        // '7',ENTER then stall with a dropped '3'; release on ready
        add(0, 1, 8'h37, 0, 32'h30303037,  0, 1, 1, 0);
        add(0, 1, 8'h0D, 0, 32'h30303037,  1, 1, 0, 0);
        add(0, 0, 8'h00, 0, 32'h30303037,  1, 1, 0, 0);
        add(0, 1, 8'h33, 0, 32'h30303037,  1, 1, 0, 1);
        add(0, 0, 8'h00, 0, 32'h30303037,  1, 1, 0, 0);
        add(0, 0, 8'h00, 0, 32'h30303037,  1, 1, 0, 0);
        add(0, 0, 8'h00, 1, B0,            0, 0, 0, 0);
        // key coinciding with the handshake edge is dropped with error
        add(0, 1, 8'h36, 0, 32'h30303036,  0, 1, 1, 0);
        add(0, 1, 8'h0D, 0, 32'h30303036,  1, 1, 0, 0);
        add(0, 1, 8'h1B, 1, B0,            0, 0, 0, 1);
        add(0, 0, 8'h00, 0, B0,            0, 0, 0, 0);
        // reset mid-COMMIT, then a normal '1',ENTER
        add(0, 1, 8'h38, 0, 32'h30303038,  0, 1, 1, 0);
        add(0, 1, 8'h0D, 0, 32'h30303038,  1, 1, 0, 0);
        add(1, 0, 8'h00, 0, B0,            0, 0, 0, 0);
        add(0, 1, 8'h31, 1, 32'h30303031,  0, 1, 1, 0);
        add(0, 1, 8'h0D, 1, 32'h30303031,  1, 1, 0, 0);
        add(0, 0, 8'h00, 1, B0,            0, 0, 0, 0);

        foreach (vec_q[i]) apply(vec_q[i]);

        // Timeout: '5' then 7 idle cycles hold, the 8th clears silently
        apply(mk(0, 1, 8'h35, 0, 32'h30303035, 0, 1, 1, 0));
        for (int k = 0; k < 7; k++) apply(mk(0, 0, 8'h00, 0, 32'h30303035, 0, 1, 1, 0));
        apply(mk(0, 0, 8'h00, 0, B0, 0, 0, 0, 0));
        apply(mk(0, 0, 8'h00, 0, B0, 0, 0, 0, 0));

        // A key part-way through restarts the idle count
        apply(mk(0, 1, 8'h35, 0, 32'h30303035, 0, 1, 1, 0));
        for (int k = 0; k < 5; k++) apply(mk(0, 0, 8'h00, 0, 32'h30303035, 0, 1, 1, 0));
        apply(mk(0, 1, 8'h36, 0, 32'h30303536, 0, 2, 1, 0));
        for (int k = 0; k < 7; k++) apply(mk(0, 0, 8'h00, 0, 32'h30303536, 0, 2, 1, 0));
        apply(mk(0, 0, 8'h00, 0, B0, 0, 0, 0, 0));

        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kb_entry_ctrl.md
# kb_entry_ctrl

Sequencing controller for keypad numeric entry. It accepts ASCII keystrokes one at a time and assembles up to four digits into a right-aligned, '0'-padded 32-bit ASCII buffer. On Enter it presents the buffer downstream with a valid/ready handshake. It sits between the keyboard scan/ASCII front end and the buffer-to-binary decoder, supplying that decoder's `buffer` and `buffer_valid` inputs.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: idle cycles in ENTRY before auto-clear; 0 disables the timeout.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_data`  in  8  ASCII code of the keystroke.
- `key_valid`  in  1  one-cycle strobe; `key_data` is valid when high.
- `buffer_ready`  in  1  downstream accepts the committed buffer.
- `buffer`  out  32  four ASCII chars, MSB char first, right-aligned.
- `buffer_valid`  out  1  committed buffer is presented.
- `digit_count`  out  3  digits currently held, 0..4.
- `entry_active`  out  1  high in ENTRY state.
- `err_pulse`  out  1  one-cycle pulse when a key is rejected.

## Operation
- Reset values: `buffer`=0x30303030 ("0000"), `buffer_valid`=0, `digit_count`=0, `entry_active`=0, `err_pulse`=0, state EMPTY, timeout counter 0.
- Key classes:
  - DIGIT: 0x30–0x39.
  - BKSP: 0x08.
  - ENTER: 0x0D.
  - ESC: 0x1B.
  - All other codes are OTHER.
- States: EMPTY (count 0), ENTRY (count 1..4), COMMIT (presenting).
- DIGIT in EMPTY/ENTRY with count<4: `buffer` <= {buffer[23:0], key_data}; count+1; go to or stay in ENTRY.
- DIGIT with count==4: buffer unchanged; `err_pulse`.
- BKSP with count≥1: `buffer` <= {8'h30, buffer[31:8]}; count−1; if count becomes 0, go to EMPTY.
- BKSP in EMPTY: `err_pulse`.
- ENTER in ENTRY: go to COMMIT; `buffer_valid`=1.
- ENTER in EMPTY: `err_pulse`.
- ESC in ENTRY: `buffer`="0000", count 0, go to EMPTY. ESC in EMPTY: no effect, no error.
- OTHER: ignored, no error.
- COMMIT:
  - `buffer` and `digit_count` are frozen.
  - `buffer_valid` holds until a cycle where `buffer_ready`=1.
  - On that edge: go to EMPTY, `buffer`="0000", count 0, `buffer_valid`=0.
- Any `key_valid` in COMMIT, including ESC, is dropped with `err_pulse`. This includes a key in the same cycle as the handshake.
- Timeout counter:
  - Increments each cycle in ENTRY without `key_valid`.
  - Clears on any accepted or rejected key and on leaving ENTRY.
  - When it reaches TIMEOUT_CYCLES−1 (TIMEOUT_CYCLES≠0), the next edge acts as ESC, with no `err_pulse`.
  - Held at 0 outside ENTRY.
  - Width: 32 bits.

## Timing
- All outputs are registered. A key sampled at edge N is reflected in `buffer`/`digit_count`/state after edge N, and `err_pulse` is high for cycle N+1 only.
- ENTER at edge N: `buffer_valid` is high from cycle N+1.
- Handshake: transfer occurs on an edge where `buffer_valid`&&`buffer_ready`. `buffer_valid`=0 the next cycle.
- Minimum key spacing is one cycle; back-to-back strobes are each processed.
- `rst` asserted at any edge, including mid-COMMIT, returns all state to reset values at that edge. `key_valid` in the same cycle is ignored.

## Structure
- Shared package `kb_pkg` holds:
  - ASCII constants `KB_ASCII_ZERO`, `KB_ASCII_BKSP`, `KB_ASCII_ENTER`, `KB_ASCII_ESC`.
  - The `kb_key_class_t` enum (DIGIT/BKSP/ENTER/ESC/OTHER).
  - The `kb_entry_state_t` enum (EMPTY/ENTRY/COMMIT).
  - The constant `KB_BUF_BLANK` = 32'h30303030.
- One combinational sub-module, `kb_key_classify`: `key_data` → `kb_key_class_t`.
- The FSM, shift buffer and timeout counter live in `kb_entry_ctrl`.

## Test plan
- Keys '4','2', ENTER with `buffer_ready`=1 → `buffer`=0x30303432 with `buffer_valid` one cycle; then "0000", count 0.
- Keys '1','2','3','4','5' → `buffer`=0x31323334, count 4, `err_pulse` on the fifth key only.
- Keys '9','8', BKSP, BKSP, BKSP → buffer 0x30303039, then "0000", count 0, `err_pulse` on the third BKSP.
- ENTER after '7' with `buffer_ready`=0 for 5 cycles, with key '3' sent during the wait → `buffer_valid` held 5 cycles at 0x30303037, '3' dropped with `err_pulse`, release on the ready cycle.
- TIMEOUT_CYCLES=8, key '5' then idle → state EMPTY and buffer "0000" exactly 8 idle cycles later, with no `err_pulse`.
- `rst` pulsed during COMMIT → `buffer_valid`=0, buffer "0000", EMPTY on the next cycle; a subsequent '1' ENTER works normally.
